// File: rtl/data_mem_arbiter_if.sv
// Purpose : bundles the CPU port, the coprocessor port and the byte-bank port of
//           the data-memory arbiter into one interface.
// Latency : n/a (wires only); grants are combinational, responses one cycle later.
// Backpressure: requesters hold *_req until the matching *_gnt is seen.
// Ports   : slave  = arbiter view (requests/bank_rdata in, grants/responses/bank controls out)
//           master = environment view (CPU, coprocessor and bank models).
interface data_mem_arbiter_if #(
  parameter int ADDRW = 15
);
  // CPU load/store unit
  logic             cpu_req;
  logic             cpu_we;
  logic [ADDRW-1:0] cpu_addr;
  logic [1:0]       cpu_size;
  logic             cpu_unsigned;
  logic [31:0]      cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_rvalid;
  logic [31:0]      cpu_rdata;
  logic             cpu_err;
  // image coprocessor (word accesses only)
  logic             cop_req;
  logic             cop_we;
  logic [ADDRW-1:0] cop_addr;
  logic [31:0]      cop_wdata;
  logic             cop_gnt;
  logic             cop_rvalid;
  logic [31:0]      cop_rdata;
  // four byte-wide banks, bank i on byte lane i
  logic [ADDRW-3:0] bank_addr;
  logic [3:0]       bank_rden;
  logic [3:0]       bank_wen;
  logic [31:0]      bank_wdata;
  logic [31:0]      bank_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  cop_req, cop_we, cop_addr, cop_wdata,
    output cop_gnt, cop_rvalid, cop_rdata,
    output bank_addr, bank_rden, bank_wen, bank_wdata,
    input  bank_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output cop_req, cop_we, cop_addr, cop_wdata,
    input  cop_gnt, cop_rvalid, cop_rdata,
    input  bank_addr, bank_rden, bank_wen, bank_wdata,
    output bank_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Purpose : shares four byte-wide data banks between the CPU LSU (fixed priority)
//           and the image coprocessor (starvation guard after STARVE_LIM lost contests).
// Latency : grant combinational in cycle N; registered rvalid/rdata/err in cycle N+1.
// Backpressure: loser keeps its request asserted; one access per cycle, back-to-back allowed.
// Ports   : clk, rst_n (async active-low), bus (data_mem_arbiter_if.slave).
module data_mem_arbiter #(
  parameter int ADDRW      = 15,
  parameter int STARVE_LIM = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_arbiter_if.slave    bus
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  // ---------------------------------------------------------------- state
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        cpu_err_q,    cpu_err_d;
  logic [31:0] cpu_rdata_q,  cpu_rdata_d;
  logic        cop_rvalid_q, cop_rvalid_d;
  logic [31:0] cop_rdata_q,  cop_rdata_d;

  // ---------------------------------------------------------- arbitration
  logic contested, cop_force, cpu_win, cop_win;

  assign contested = bus.cpu_req & bus.cop_req;
  assign cop_force = contested && (starve_cnt_q == LIM);
  // Grants are qualified by rst_n so every output drops while reset is held.
  assign cpu_win   = rst_n & bus.cpu_req & ~cop_force;
  assign cop_win   = rst_n & bus.cop_req & (~bus.cpu_req | cop_force);

  assign bus.cpu_gnt = cpu_win;
  assign bus.cop_gnt = cop_win;

  // --------------------------------------------------------- CPU decode
  logic [1:0]  cpu_a;
  logic [3:0]  cpu_mask;
  logic        cpu_bad;
  logic [31:0] cpu_wsteer;

  assign cpu_a = bus.cpu_addr[1:0];

  always_comb begin
    cpu_mask = 4'b0000;
    cpu_bad  = 1'b0;
    case (bus.cpu_size)
      2'b00: cpu_mask = 4'b0001 << cpu_a;
      2'b01: begin
        if (cpu_a[0]) cpu_bad  = 1'b1;
        else          cpu_mask = cpu_a[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        if (cpu_a != 2'b00) cpu_bad  = 1'b1;
        else                cpu_mask = 4'b1111;
      end
      default: cpu_bad = 1'b1;
    endcase
  end

  // Replication puts the store data on whichever lanes the mask enables.
  always_comb begin
    case (bus.cpu_size)
      2'b00:   cpu_wsteer = {4{bus.cpu_wdata[7:0]}};
      2'b01:   cpu_wsteer = {2{bus.cpu_wdata[15:0]}};
      default: cpu_wsteer = bus.cpu_wdata;
    endcase
  end

  // --------------------------------------------------------- bank drive
  always_comb begin
    bus.bank_addr  = '0;
    bus.bank_rden  = 4'b0000;
    bus.bank_wen   = 4'b0000;
    bus.bank_wdata = 32'h0;
    if (cpu_win) begin
      bus.bank_addr = bus.cpu_addr[ADDRW-1:2];
      if (bus.cpu_we) begin
        bus.bank_wdata = cpu_wsteer;
        if (!cpu_bad) bus.bank_wen = cpu_mask;
      end else if (!cpu_bad) begin
        bus.bank_rden = cpu_mask;
      end
    end else if (cop_win) begin
      bus.bank_addr = bus.cop_addr[ADDRW-1:2];
      if (bus.cop_we) begin
        bus.bank_wen   = 4'b1111;
        bus.bank_wdata = bus.cop_wdata;
      end else begin
        bus.bank_rden  = 4'b1111;
      end
    end
  end

  // Coprocessor accesses are word-aligned by construction; low bits are dropped.
  logic unused_cop_lsb;
  assign unused_cop_lsb = ^bus.cop_addr[1:0];

  // ------------------------------------------------------ read alignment
  logic [31:0] lane_bits, cpu_sel, cpu_shift, cpu_ext;

  assign lane_bits = {{8{cpu_mask[3]}}, {8{cpu_mask[2]}}, {8{cpu_mask[1]}}, {8{cpu_mask[0]}}};
  assign cpu_sel   = bus.bank_rdata & lane_bits;
  assign cpu_shift = cpu_sel >> {cpu_a, 3'b000};

  always_comb begin
    case (bus.cpu_size)
      2'b00:   cpu_ext = {{24{~bus.cpu_unsigned & cpu_shift[7]}},  cpu_shift[7:0]};
      2'b01:   cpu_ext = {{16{~bus.cpu_unsigned & cpu_shift[15]}}, cpu_shift[15:0]};
      default: cpu_ext = cpu_shift;
    endcase
  end

  // ---------------------------------------------------------- next state
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    cpu_rvalid_d = cpu_win;
    cpu_err_d    = cpu_win & cpu_bad;
    cpu_rdata_d  = 32'h0;
    cop_rvalid_d = cop_win;
    cop_rdata_d  = 32'h0;

    if (cpu_win && !bus.cpu_we && !cpu_bad) cpu_rdata_d = cpu_ext;
    if (cop_win && !bus.cop_we)             cop_rdata_d = bus.bank_rdata;

    // Counts contests the CPU has won in a row; forced coprocessor win resets it.
    if (cop_win)                 starve_cnt_d = 4'd0;
    else if (contested && cpu_win) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= 32'h0;
      cop_rvalid_q <= 1'b0;
      cop_rdata_q  <= 32'h0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_err_q    <= cpu_err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cop_rvalid_q <= cop_rvalid_d;
      cop_rdata_q  <= cop_rdata_d;
    end
  end

  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_err    = cpu_err_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cop_rvalid = cop_rvalid_q;
  assign bus.cop_rdata  = cop_rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the four byte-wide data-memory banks between the CPU load/store unit and the image coprocessor.
- Bank i holds byte lane i of every 32-bit word.
- Arbitrates per cycle: CPU has fixed priority, with a starvation guard for the coprocessor.
- Generates per-bank enables and lane-steered write data; aligns and extends read data.
- Returns a registered response one cycle after grant.

Parameters:
- ADDRW, 15, byte address width; bank address width is ADDRW-2.
- STARVE_LIM, 4, consecutive contested CPU wins after which the coprocessor is forced to win; range 1..15.

Ports:
- clk  input  1  global clock; banks operate on negedge, this block on posedge
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  CPU access request, held until cpu_gnt
- cpu_we  input  1  1=store, 0=load
- cpu_addr  input  ADDRW  byte address
- cpu_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- cpu_unsigned  input  1  zero-extend loads when 1, sign-extend when 0
- cpu_wdata  input  32  store data, right-justified
- cpu_gnt  output  1  combinational; request accepted this cycle
- cpu_rvalid  output  1  registered response pulse
- cpu_rdata  output  32  registered load data, aligned and extended
- cpu_err  output  1  registered; valid with cpu_rvalid; misaligned or illegal size
- cop_req  input  1  coprocessor word request; addr[1:0] ignored
- cop_we  input  1  1=store
- cop_addr  input  ADDRW  byte address
- cop_wdata  input  32  store word
- cop_gnt  output  1  combinational grant
- cop_rvalid  output  1  registered response pulse
- cop_rdata  output  32  registered load word
- bank_addr  output  ADDRW-2  shared bank address = granted addr[ADDRW-1:2]
- bank_rden  output  4  per-lane read enable
- bank_wen  output  4  per-lane write enable
- bank_wdata  output  32  byte i drives bank i Data_In
- bank_rdata  input  32  byte i from bank i Data_Out; a bank returns 0 when its rden is low

Behaviour:
- Arbitration is combinational within cycle N.
  - Only one requester asserting: that requester wins.
  - Both asserting: the CPU wins unless starve_cnt == STARVE_LIM, in which case the coprocessor wins.
- starve_cnt (4 bits, posedge):
  - Increments when both request and the CPU wins.
  - Clears when the coprocessor is granted.
  - Holds otherwise.
- At most one of cpu_gnt and cop_gnt is high in any cycle. A grant is never given without the matching req.
- CPU error condition: size 11; half with addr[0]=1; word with addr[1:0]≠00.
  - An erroring CPU request is still granted and consumed.
  - bank_rden = bank_wen = 0 for that request.
  - Response: cpu_rvalid=1, cpu_err=1, cpu_rdata=0 in cycle N+1.
- CPU lane mask, with a = addr[1:0]:
  - byte: 1<<a
  - half: 0011 for a=00, 1100 for a=10
  - word: 1111
  - Load drives bank_rden = mask. Store drives bank_wen = mask.
- CPU write steering on bank_wdata:
  - byte: wdata[7:0] replicated to all four lanes.
  - half: wdata[15:0] replicated to both halves.
  - word: wdata passed through.
- Coprocessor: mask = 1111; bank_wdata = cop_wdata.
- No grant: bank_rden = bank_wen = 0; bank_addr and bank_wdata = 0.
- Read return:
  - At the posedge ending cycle N, the selected lanes of bank_rdata are shifted down by 8*a.
  - The result is zero- or sign-extended per cpu_unsigned and cpu_size (coprocessor: raw word), then registered.
- Response timing:
  - rvalid pulses for exactly one cycle (N+1) for every granted request, loads and stores alike.
  - For stores, rdata = 0.
  - rdata is 0 whenever rvalid is 0.
- Back-to-back grants to either requester are allowed every cycle. Throughput is 1 access/cycle.
- Reset values: cpu_rvalid, cpu_err, cop_rvalid = 0; cpu_rdata, cop_rdata = 0; starve_cnt = 0.
  - Reset asserted mid-access discards the pending response; no rvalid is issued after reset release.
  - Bank contents are unaffected by reset.

Test Plan:
- CPU word store 0xDEADBEEF @0x0100 then word load @0x0100 → bank_wen=1111, bank_addr=0x040; load cycle N+1: cpu_rvalid=1, cpu_rdata=0xDEADBEEF, cpu_err=0.
- CPU signed byte load @0x0103 (memory 0xDEADBEEF) → bank_rden=1000, cpu_rdata=0xFFFFFFDE; unsigned half load @0x0102 → bank_rden=1100, cpu_rdata=0x0000DEAD.
- CPU byte store 0x5A @0x0101 over 0xDEADBEEF → bank_wen=0010, bank_wdata=0x5A5A5A5A; subsequent word load returns 0xDEAD5AEF.
- CPU half load @0x0101 and word store @0x0102 → granted, banks untouched; each gives cpu_rvalid=1, cpu_err=1, cpu_rdata=0 the next cycle.
- Both requesting continuously, STARVE_LIM=4 → grant sequence CPU,CPU,CPU,CPU,COP repeating; starve_cnt returns to 0 after each COP grant; never both grants high.
- rst_n pulled low the cycle after a CPU load grant → cpu_rvalid stays 0; all outputs 0 asynchronously; first post-reset contested cycle grants the CPU.
